// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: serializes a 4-bit word through a 4:1 mux select sweep with framing strobes
module mux_scan_ctrl #(
  parameter int BIT_PERIOD = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  input  logic [3:0] load_data,
  output logic       load_ready,
  input  logic       pause,
  output logic [1:0] sel,
  output logic [3:0] word,
  output logic       bit_valid,
  output logic       first_bit,
  output logic       last_bit,
  output logic       busy
);
  localparam int TW = BIT_PERIOD > 1 ? $clog2(BIT_PERIOD) : 1;
  localparam logic [TW-1:0] TMAX = TW'(BIT_PERIOD - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [TW-1:0] tick, tick_n;
  logic [3:0] word_n;
  logic bit_end, accept;
  // state, bit index, tick and held word registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= 2'd0;
      tick <= '0;
      word <= 4'd0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      tick <= tick_n;
      word <= word_n;
    end
  end
  // handshake, strobes and next-state; a load at the frame's final bit restarts without a gap
  always_comb begin
    busy = state == SHIFT;
    bit_valid = busy && !pause;
    bit_end = bit_valid && tick == TMAX;
    load_ready = !busy || (bit_end && idx == 2'd3);
    accept = load_valid && load_ready;
    first_bit = bit_valid && idx == 2'd0;
    last_bit = bit_valid && idx == 2'd3;
    sel = MSB_FIRST ? ~idx : idx;
    state_n = state;
    idx_n = idx;
    tick_n = tick;
    word_n = word;
    if (accept) begin
      state_n = SHIFT;
      idx_n = 2'd0;
      tick_n = '0;
      word_n = load_data;
    end else if (bit_end) begin
      tick_n = '0;
      idx_n = idx + 2'd1;
      state_n = idx == 2'd3 ? IDLE : SHIFT;
    end else if (bit_valid) begin
      tick_n = tick + 1'b1;
    end
  end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: two configurations checked cycle by cycle against a frame-position model
module tb_mux_scan_ctrl;
  logic clk = 1'b0;
  logic rst, load_valid, pause;
  logic [3:0] load_data;
  logic load_ready [2];
  logic [1:0] sel [2];
  logic [3:0] word [2];
  logic bit_valid [2], first_bit [2], last_bit [2], busy [2];
  int checks = 0, errors = 0;
  int bp [2] = '{1, 3};
  bit msb [2] = '{1'b0, 1'b1};
  bit m_busy [2];
  int m_pos [2];
  logic [3:0] m_word [2];

  always #5 clk = ~clk;

  mux_scan_ctrl #(.BIT_PERIOD(1), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready[0]), .pause(pause), .sel(sel[0]), .word(word[0]),
    .bit_valid(bit_valid[0]), .first_bit(first_bit[0]), .last_bit(last_bit[0]), .busy(busy[0]));

  mux_scan_ctrl #(.BIT_PERIOD(3), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready[1]), .pause(pause), .sel(sel[1]), .word(word[1]),
    .bit_valid(bit_valid[1]), .first_bit(first_bit[1]), .last_bit(last_bit[1]), .busy(busy[1]));

  task automatic chk(input string tag, input int m, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[u%0d] observed=%0d expected=%0d", tag, m, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      int bit_no, pos_sel, e_ready, e_bv;
      logic [3:0] w;
      bit_no = m_pos[m] / bp[m];
      pos_sel = msb[m] ? 3 - bit_no : bit_no;
      e_bv = m_busy[m] && !pause;
      e_ready = !m_busy[m] || (m_pos[m] == 4 * bp[m] - 1 && !pause);
      w = word[m];
      chk("busy", m, busy[m], m_busy[m]);
      chk("load_ready", m, load_ready[m], e_ready);
      chk("bit_valid", m, bit_valid[m], e_bv);
      chk("first_bit", m, first_bit[m], e_bv && bit_no == 0);
      chk("last_bit", m, last_bit[m], e_bv && bit_no == 3);
      chk("sel", m, sel[m], m_busy[m] ? pos_sel : (msb[m] ? 3 : 0));
      chk("word", m, word[m], m_word[m]);
      if (e_bv) chk("mux_out", m, w[sel[m]], m_word[m][pos_sel]);
    end
  endtask

  task automatic update_model();
    for (int m = 0; m < 2; m++) begin
      bit ready;
      ready = !m_busy[m] || (m_pos[m] == 4 * bp[m] - 1 && !pause);
      if (rst) begin
        m_busy[m] = 1'b0;
        m_pos[m] = 0;
        m_word[m] = 4'd0;
      end else if (ready && load_valid) begin
        m_busy[m] = 1'b1;
        m_pos[m] = 0;
        m_word[m] = load_data;
      end else if (m_busy[m] && !pause) begin
        if (m_pos[m] == 4 * bp[m] - 1) begin
          m_busy[m] = 1'b0;
          m_pos[m] = 0;
        end else m_pos[m]++;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit lv, input logic [3:0] ld, input bit p);
    rst = r;
    load_valid = lv;
    load_data = ld;
    pause = p;
    #1;
    if (!$isunknown(busy[0])) check_all();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 1'b0;
      m_pos[m] = 0;
      m_word[m] = 4'd0;
    end
    rst = 1'b1;
    load_valid = 1'b1;
    load_data = 4'hF;
    pause = 1'b0;
    @(negedge clk);
    cyc(1, 1, 4'hF, 0);
    cyc(1, 1, 4'hF, 0);
    cyc(0, 1, 4'b1011, 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 4'h0, 0);
    cyc(0, 1, 4'b0110, 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 4'h0, 0);
    cyc(0, 1, 4'hA, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 4'h5, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 4'h5, 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 4'h0, 0);
    cyc(0, 1, 4'b1001, 0);
    cyc(0, 0, 4'h0, 0);
    cyc(0, 0, 4'h0, 1);
    cyc(0, 0, 4'h0, 1);
    for (int i = 0; i < 14; i++) cyc(0, 0, 4'h0, 0);
    cyc(0, 1, 4'b0111, 0);
    cyc(0, 0, 4'h0, 0);
    cyc(1, 1, 4'h3, 0);
    cyc(0, 1, 4'b1100, 0);
    for (int i = 0; i < 14; i++) cyc(0, 0, 4'h0, 0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
          4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
